// File: rtl/dpram_mig_model.sv
// dpram_mig_model
// On-chip stand-in for a MIG user-interface port. Commands and write data
// enter two independent FIFOs, and they are paired in order by the issue
// logic. The design has a byte-maskable RAM, a fixed-latency read return
// path and a calibration delay after reset.
module dpram_mig_model #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DWIDTH         = 128,
  parameter int CMD_DEPTH_BITS = 3,
  parameter int WDF_DEPTH_BITS = 3,
  parameter int RD_LATENCY     = 2,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  output logic                    init_calib_complete,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DWIDTH-1:0]       app_wdf_data,
  input  logic [DWIDTH/8-1:0]     app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DWIDTH-1:0]       app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    err_bad_cmd
);

  localparam int NBYTES    = DWIDTH / 8;
  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int CMD_DEPTH = 2 ** CMD_DEPTH_BITS;
  localparam int WDF_DEPTH = 2 ** WDF_DEPTH_BITS;
  localparam int CMDW      = 3 + ADDR_WIDTH;
  localparam int WDFW      = NBYTES + DWIDTH;
  localparam int CALW      = 17;

  localparam logic [CALW-1:0] CALIB_TGT = CALW'(CALIB_CYCLES);
  localparam logic [CALW-1:0] CALIB_ONE = CALW'(1);

  localparam logic [CMD_DEPTH_BITS:0]   CMD_FULL    = {1'b1, {CMD_DEPTH_BITS{1'b0}}};
  localparam logic [CMD_DEPTH_BITS:0]   CMD_CNT_ONE = (CMD_DEPTH_BITS + 1)'(1);
  localparam logic [CMD_DEPTH_BITS-1:0] CMD_PTR_ONE = CMD_DEPTH_BITS'(1);
  localparam logic [WDF_DEPTH_BITS:0]   WDF_FULL    = {1'b1, {WDF_DEPTH_BITS{1'b0}}};
  localparam logic [WDF_DEPTH_BITS:0]   WDF_CNT_ONE = (WDF_DEPTH_BITS + 1)'(1);
  localparam logic [WDF_DEPTH_BITS-1:0] WDF_PTR_ONE = WDF_DEPTH_BITS'(1);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_WAIT_WDATA = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CALW-1:0]           calib_cnt_q, calib_cnt_d;
  logic                      calib_done_q, calib_done_d;
  logic                      app_rdy_q, app_rdy_d;
  logic                      app_wdf_rdy_q, app_wdf_rdy_d;
  logic                      err_q, err_d;

  logic [CMDW-1:0]           cmd_mem_q [CMD_DEPTH];
  logic [CMD_DEPTH_BITS-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [CMD_DEPTH_BITS:0]   cmd_cnt_q, cmd_cnt_d;

  logic [WDFW-1:0]           wdf_mem_q [WDF_DEPTH];
  logic [WDF_DEPTH_BITS-1:0] wdf_wptr_q, wdf_wptr_d, wdf_rptr_q, wdf_rptr_d;
  logic [WDF_DEPTH_BITS:0]   wdf_cnt_q, wdf_cnt_d;

  state_e                    state_q, state_d;

  logic [DWIDTH-1:0]         ram_q [RAM_DEPTH];
  logic [DWIDTH-1:0]         rd_pipe_data_q [RD_LATENCY];
  logic [RD_LATENCY-1:0]     rd_pipe_vld_q, rd_pipe_vld_d;
  logic [DWIDTH-1:0]         rd_data_q;
  logic                      rd_valid_q;

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  logic                      cmd_push_s, cmd_pop_s, cmd_empty_s;
  logic                      wdf_push_s, wdf_pop_s, wdf_empty_s;
  logic [2:0]                head_cmd_s;
  logic [ADDR_WIDTH-1:0]     head_addr_s;
  logic [NBYTES-1:0]         wdf_head_mask_s;
  logic [DWIDTH-1:0]         wdf_head_data_s;
  logic                      issue_rd_s, issue_wr_s, issue_bad_s;
  logic                      unused_s;

  // Single-beat protocol: the end-of-burst marker carries no information.
  assign unused_s = app_wdf_end;

  // Handshakes only count when the matching ready was presented.
  assign cmd_push_s  = app_en & app_rdy_q;
  assign wdf_push_s  = app_wdf_wren & app_wdf_rdy_q;
  assign cmd_empty_s = (cmd_cnt_q == '0);
  assign wdf_empty_s = (wdf_cnt_q == '0);

  assign {head_cmd_s, head_addr_s}          = cmd_mem_q[cmd_rptr_q];
  assign {wdf_head_mask_s, wdf_head_data_s} = wdf_mem_q[wdf_rptr_q];

  assign cmd_pop_s = issue_rd_s | issue_wr_s | issue_bad_s;
  assign wdf_pop_s = issue_wr_s;

  // ---------------------------------------------------------------------
  // Calibration delay and registered readiness
  // ---------------------------------------------------------------------

  // Count edges after reset release until the calibration target is reached.
  always_comb begin
    calib_cnt_d  = calib_cnt_q;
    calib_done_d = calib_done_q;
    if (!calib_done_q) begin
      calib_cnt_d  = calib_cnt_q + CALIB_ONE;
      calib_done_d = (calib_cnt_d == CALIB_TGT);
    end else begin
      calib_cnt_d  = calib_cnt_q;
      calib_done_d = 1'b1;
    end
  end

  // Ready flags are computed from next-state so the registered value equals
  // the condition on the current (pre-pop) queue counts.
  always_comb begin
    app_rdy_d     = calib_done_d & (cmd_cnt_d < CMD_FULL);
    app_wdf_rdy_d = calib_done_d & (wdf_cnt_d < WDF_FULL);
  end

  // ---------------------------------------------------------------------
  // Command and write-data FIFO bookkeeping
  // ---------------------------------------------------------------------

  // Next pointer and occupancy for both queues.
  always_comb begin
    cmd_wptr_d = cmd_push_s ? (cmd_wptr_q + CMD_PTR_ONE) : cmd_wptr_q;
    cmd_rptr_d = cmd_pop_s  ? (cmd_rptr_q + CMD_PTR_ONE) : cmd_rptr_q;
    wdf_wptr_d = wdf_push_s ? (wdf_wptr_q + WDF_PTR_ONE) : wdf_wptr_q;
    wdf_rptr_d = wdf_pop_s  ? (wdf_rptr_q + WDF_PTR_ONE) : wdf_rptr_q;
    case ({cmd_push_s, cmd_pop_s})
      2'b10:   cmd_cnt_d = cmd_cnt_q + CMD_CNT_ONE;
      2'b01:   cmd_cnt_d = cmd_cnt_q - CMD_CNT_ONE;
      default: cmd_cnt_d = cmd_cnt_q;
    endcase
    case ({wdf_push_s, wdf_pop_s})
      2'b10:   wdf_cnt_d = wdf_cnt_q + WDF_CNT_ONE;
      2'b01:   wdf_cnt_d = wdf_cnt_q - WDF_CNT_ONE;
      default: wdf_cnt_d = wdf_cnt_q;
    endcase
  end

  // Queue storage: written on accept, contents need no reset.
  always_ff @(posedge sys_clk) begin
    if (cmd_push_s) begin
      cmd_mem_q[cmd_wptr_q] <= {app_cmd, app_addr};
    end
    if (wdf_push_s) begin
      wdf_mem_q[wdf_wptr_q] <= {app_wdf_mask, app_wdf_data};
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM: IDLE decodes the head, WAIT_WDATA parks a write that has no
  // data yet and keeps every later command behind it.
  // ---------------------------------------------------------------------

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty_s && (head_cmd_s == CMD_WR) && wdf_empty_s) begin
          state_d = ST_WAIT_WDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_WDATA: begin
        if (!wdf_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_WDATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: which kind of command, if any, is issued this cycle.
  always_comb begin
    issue_rd_s  = 1'b0;
    issue_wr_s  = 1'b0;
    issue_bad_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty_s) begin
          case (head_cmd_s)
            CMD_WR:  issue_wr_s  = !wdf_empty_s;
            CMD_RD:  issue_rd_s  = 1'b1;
            default: issue_bad_s = 1'b1;
          endcase
        end else begin
          issue_wr_s = 1'b0;
        end
      end
      ST_WAIT_WDATA: issue_wr_s = !cmd_empty_s && !wdf_empty_s;
      default:       issue_wr_s = 1'b0;
    endcase
  end

  // Sticky flag for illegal command codes.
  always_comb begin
    err_d = err_q | issue_bad_s;
  end

  // ---------------------------------------------------------------------
  // RAM and read return path
  // ---------------------------------------------------------------------

  // Byte-masked RAM write; a set mask bit protects that byte.
  always_ff @(posedge sys_clk) begin
    if (issue_wr_s) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (!wdf_head_mask_s[b]) begin
          ram_q[head_addr_s][b*8 +: 8] <= wdf_head_data_s[b*8 +: 8];
        end
      end
    end
  end

  // Read data capture and delay line; validity is tracked separately.
  always_ff @(posedge sys_clk) begin
    if (issue_rd_s) begin
      rd_pipe_data_q[0] <= ram_q[head_addr_s];
    end
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_pipe_data_q[k] <= rd_pipe_data_q[k-1];
    end
  end

  // Valid shift line, aligned with the data delay line.
  always_comb begin
    rd_pipe_vld_d[0] = issue_rd_s;
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_pipe_vld_d[k] = rd_pipe_vld_q[k-1];
    end
  end

  // All resettable control state, including the registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      calib_cnt_q   <= '0;
      calib_done_q  <= 1'b0;
      app_rdy_q     <= 1'b0;
      app_wdf_rdy_q <= 1'b0;
      err_q         <= 1'b0;
      cmd_wptr_q    <= '0;
      cmd_rptr_q    <= '0;
      cmd_cnt_q     <= '0;
      wdf_wptr_q    <= '0;
      wdf_rptr_q    <= '0;
      wdf_cnt_q     <= '0;
      rd_pipe_vld_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      calib_cnt_q   <= calib_cnt_d;
      calib_done_q  <= calib_done_d;
      app_rdy_q     <= app_rdy_d;
      app_wdf_rdy_q <= app_wdf_rdy_d;
      err_q         <= err_d;
      cmd_wptr_q    <= cmd_wptr_d;
      cmd_rptr_q    <= cmd_rptr_d;
      cmd_cnt_q     <= cmd_cnt_d;
      wdf_wptr_q    <= wdf_wptr_d;
      wdf_rptr_q    <= wdf_rptr_d;
      wdf_cnt_q     <= wdf_cnt_d;
      rd_pipe_vld_q <= rd_pipe_vld_d;
      rd_valid_q    <= rd_pipe_vld_q[RD_LATENCY-1];
      // Read data holds its last value between beats.
      if (rd_pipe_vld_q[RD_LATENCY-1]) begin
        rd_data_q <= rd_pipe_data_q[RD_LATENCY-1];
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  assign init_calib_complete = calib_done_q;
  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = app_wdf_rdy_q;
  assign app_rd_data         = rd_data_q;
  assign app_rd_data_valid   = rd_valid_q;
  assign app_rd_data_end     = rd_valid_q;
  assign err_bad_cmd         = err_q;

endmodule

// File: tb/tb_dpram_mig_model.sv
// Directed, table-driven bench for dpram_mig_model with default parameters.
module tb_dpram_mig_model;

  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          init_calib_complete;
  logic [11:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [127:0]  app_wdf_data;
  logic [15:0]   app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [127:0]  app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          err_bad_cmd;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]   cmd;
    logic [11:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    logic [127:0] exp;
  } vec_t;

  vec_t vt[10];

  dpram_mig_model dut (
    .sys_clk             (sys_clk),
    .sys_rst_n           (sys_rst_n),
    .init_calib_complete (init_calib_complete),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .err_bad_cmd         (err_bad_cmd)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a command (optionally with its data beat), wait for ready, accept it.
  task automatic send(input logic [2:0] c, input logic [11:0] a, input bit wd,
                      input logic [127:0] d, input logic [15:0] m);
    int w;
    w = 0;
    app_en  = 1'b1;
    app_cmd = c;
    app_addr = a;
    if (wd) begin
      app_wdf_wren = 1'b1;
      app_wdf_data = d;
      app_wdf_mask = m;
    end
    while (!(app_rdy && (!wd || app_wdf_rdy)) && (w < 50)) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_ready: got timeout expected ready within 50 cycles");
    end
    tick();
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
  endtask

  // Watch n edges; report beat count, first beat edge index and last beat data.
  task automatic collect(input int n, output int beats, output int first,
                         output logic [127:0] d, output int bad_end);
    beats = 0;
    first = -1;
    d = '0;
    bad_end = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (app_rd_data_valid) begin
        beats++;
        if (first < 0) first = k;
        d = app_rd_data;
      end
      if (app_rd_data_end !== app_rd_data_valid) bad_end++;
    end
  endtask

  initial begin
    int beats, first, bad_end, acc;
    logic [127:0] d;
    logic [7:0] jb;

    vt[0] = '{WR, 12'd5,    128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000, 128'h0};
    vt[1] = '{RD, 12'd5,    128'h0, 16'h0000, 128'h0123456789ABCDEF0123456789ABCDEF};
    vt[2] = '{WR, 12'd7,    {16{8'hFF}}, 16'h0000, 128'h0};
    vt[3] = '{WR, 12'd7,    {16{8'h00}}, 16'h00FF, 128'h0};
    vt[4] = '{RD, 12'd7,    128'h0, 16'h0000, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}};
    vt[5] = '{WR, 12'd4095, {16{8'hA5}}, 16'h0000, 128'h0};
    vt[6] = '{RD, 12'd4095, 128'h0, 16'h0000, {16{8'hA5}}};
    vt[7] = '{WR, 12'd0,    {16{8'h11}}, 16'h0000, 128'h0};
    vt[8] = '{WR, 12'd0,    {16{8'h22}}, 16'hAAAA, 128'h0};
    vt[9] = '{RD, 12'd0,    128'h0, 16'h0000, {8{16'h1122}}};

    sys_rst_n    = 1'b0;
    app_addr     = '0;
    app_cmd      = '0;
    app_en       = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_calib", 128'(init_calib_complete), 128'd0);
    chk("rst_rdy",   128'({app_rdy, app_wdf_rdy}), 128'd0);
    chk("rst_valid", 128'({app_rd_data_valid, app_rd_data_end}), 128'd0);
    chk("rst_err",   128'(err_bad_cmd), 128'd0);
    chk("rst_data",  app_rd_data, 128'd0);

    // Calibration with app_en held high throughout
    app_en = 1'b1;
    app_cmd = RD;
    app_addr = 12'd0;
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("calib_edge%0d", k),
          128'({init_calib_complete, app_rdy, app_wdf_rdy}),
          (k >= 16) ? 128'd7 : 128'd0);
    end
    tick();
    app_en = 1'b0;
    collect(8, beats, first, d, bad_end);
    chk("calib_read_beats", 128'(beats), 128'd1);
    chk("calib_read_lat",   128'(first), 128'd3);

    // Table-driven write/read vectors
    for (int i = 0; i < 10; i++) begin
      send(vt[i].cmd, vt[i].addr, vt[i].cmd == WR, vt[i].data, vt[i].mask);
      collect(6, beats, first, d, bad_end);
      if (vt[i].cmd == RD) begin
        chk($sformatf("v%0d_beats", i), 128'(beats), 128'd1);
        chk($sformatf("v%0d_lat", i),   128'(first), 128'd3);
        chk($sformatf("v%0d_data", i),  d, vt[i].exp);
        chk($sformatf("v%0d_end", i),   128'(bad_end), 128'd0);
        chk($sformatf("v%0d_hold", i),  app_rd_data, vt[i].exp);
      end else begin
        chk($sformatf("v%0d_nobeat", i), 128'(beats), 128'd0);
      end
    end
    chk("err_clean", 128'(err_bad_cmd), 128'd0);

    // Write data withheld behind its command; a later read must wait
    send(WR, 12'd3, 1'b1, {16{8'h33}}, 16'h0000);
    collect(4, beats, first, d, bad_end);
    send(WR, 12'd3, 1'b0, 128'h0, 16'h0000);
    send(RD, 12'd3, 1'b0, 128'h0, 16'h0000);
    collect(10, beats, first, d, bad_end);
    chk("wait_nobeat", 128'(beats), 128'd0);
    app_wdf_wren = 1'b1;
    app_wdf_data = {16{8'h44}};
    app_wdf_mask = 16'h0000;
    tick();
    app_wdf_wren = 1'b0;
    collect(8, beats, first, d, bad_end);
    chk("wait_beats", 128'(beats), 128'd1);
    chk("wait_lat",   128'(first), 128'd4);
    chk("wait_data",  d, {16{8'h44}});

    // Command queue fills at 8 while the head write waits for data
    repeat (2) tick();
    acc = 0;
    app_en = 1'b1;
    app_cmd = WR;
    app_addr = 12'd10;
    for (int k = 0; k < 12; k++) begin
      if (app_rdy) acc++;
      tick();
    end
    chk("full_accepts", 128'(acc), 128'd8);
    chk("full_rdy_low", 128'(app_rdy), 128'd0);
    app_wdf_wren = 1'b1;
    app_wdf_data = {16{8'hA0}};
    tick();
    app_wdf_wren = 1'b0;
    chk("full_rdy_data_edge", 128'(app_rdy), 128'd0);
    tick();
    chk("full_rdy_after_pop", 128'(app_rdy), 128'd1);
    tick();
    chk("full_rdy_ninth", 128'(app_rdy), 128'd0);
    app_en = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      jb = 8'(j);
      app_wdf_wren = 1'b1;
      app_wdf_data = {16{jb}};
      tick();
    end
    app_wdf_wren = 1'b0;
    repeat (3) tick();
    chk("drain_rdy", 128'({app_rdy, app_wdf_rdy}), 128'd3);
    send(RD, 12'd10, 1'b0, 128'h0, 16'h0000);
    collect(6, beats, first, d, bad_end);
    chk("drain_beats", 128'(beats), 128'd1);
    chk("drain_lat",   128'(first), 128'd3);
    chk("drain_data",  d, {16{8'h08}});

    // Illegal command then a read
    send(3'b010, 12'd0, 1'b0, 128'h0, 16'h0000);
    send(RD, 12'd0, 1'b0, 128'h0, 16'h0000);
    collect(6, beats, first, d, bad_end);
    chk("bad_beats", 128'(beats), 128'd1);
    chk("bad_lat",   128'(first), 128'd3);
    chk("bad_data",  d, {8{16'h1122}});
    chk("bad_err",   128'(err_bad_cmd), 128'd1);
    repeat (5) tick();
    chk("bad_err_sticky", 128'(err_bad_cmd), 128'd1);

    // Reset with a read in flight
    send(RD, 12'd5, 1'b0, 128'h0, 16'h0000);
    tick();
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        128'({init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, err_bad_cmd}),
        128'd0);
    chk("mid_rst_data", app_rd_data, 128'd0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    beats = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (app_rd_data_valid) beats++;
      if (k == 15) chk("recal_15", 128'(init_calib_complete), 128'd0);
      if (k == 16) chk("recal_16", 128'(init_calib_complete), 128'd1);
    end
    chk("mid_rst_nobeat", 128'(beats), 128'd0);
    chk("mid_rst_err",    128'(err_bad_cmd), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
